// File: rtl/wb_pkg.sv
// Shared Wishbone definitions: bridge FSM states, request record and default bus widths
// used by wb_master_bridge and wb_xbar.
package wb_pkg;

   localparam int WB_ADR_WIDTH = 32;
   localparam int WB_DAT_WIDTH = 32;
   localparam int WB_SEL_WIDTH = WB_DAT_WIDTH / 8;

   typedef enum logic [1:0] {
      WB_IDLE = 2'd0,
      WB_BUS  = 2'd1,
      WB_RESP = 2'd2
   } wb_state_t;

   typedef struct packed {
      logic [WB_ADR_WIDTH-1:0] adr;
      logic                    we;
      logic [WB_DAT_WIDTH-1:0] datwr;
      logic [WB_SEL_WIDTH-1:0] sel;
   } wb_req_t;

endpackage

// File: rtl/wishbone_bus_if.sv
// Wishbone classic-cycle bus bundle with master and slave views.
interface wishbone_bus_if
   import wb_pkg::*;
#(
   parameter int adr_width = WB_ADR_WIDTH,
   parameter int dat_width = WB_DAT_WIDTH,
   parameter int sel_width = dat_width / 8
) ();

   logic                 cyc;
   logic                 stb;
   logic                 we;
   logic [adr_width-1:0] adr;
   logic [dat_width-1:0] datwr;
   logic [sel_width-1:0] sel;
   logic                 ack;
   logic [dat_width-1:0] datrd;

   modport m_modport (
      output cyc, stb, we, adr, datwr, sel,
      input  ack, datrd
   );

   modport s_modport (
      input  cyc, stb, we, adr, datwr, sel,
      output ack, datrd
   );

endinterface

// File: rtl/wb_master_bridge.sv
// Core valid/ready request -> single Wishbone classic transfer -> valid/ready response.
// Optional ack timeout with resp_err: define WB_MASTER_BRIDGE_TIMEOUT_EN.
//
// state   | meaning
// --------+-----------------------------------------------------------
// WB_IDLE | waiting for a core request, req_ready=1
// WB_BUS  | cyc/stb asserted, waiting for ack (or timeout)
// WB_RESP | resp_valid=1, holding the response until resp_ready
module wb_master_bridge
   import wb_pkg::*;
#(
   parameter int adr_width = WB_ADR_WIDTH,
   parameter int dat_width = WB_DAT_WIDTH,
   parameter int sel_width = dat_width / 8
`ifdef WB_MASTER_BRIDGE_TIMEOUT_EN
   ,
   parameter int timeout_cycles = 255
`endif
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic [adr_width-1:0] req_adr,
   input  logic                 req_we,
   input  logic [dat_width-1:0] req_datwr,
   input  logic [sel_width-1:0] req_sel,
   output logic                 resp_valid,
   input  logic                 resp_ready,
   output logic [dat_width-1:0] resp_datrd,
`ifdef WB_MASTER_BRIDGE_TIMEOUT_EN
   output logic                 resp_err,
`endif
   wishbone_bus_if.m_modport    wb
);

   wb_state_t state;

`ifdef WB_MASTER_BRIDGE_TIMEOUT_EN
   localparam int cnt_width = $clog2(timeout_cycles + 1);
   // Down-counter loaded on BUS entry; the cycle it sits at zero is the limit cycle.
   localparam logic [cnt_width-1:0] cnt_load = cnt_width'(timeout_cycles - 1);
   logic [cnt_width-1:0] tmo_cnt;
`endif

   always_ff @(posedge clock) begin
      if (!reset) begin
         state      <= WB_IDLE;
         req_ready  <= 1'b0;
         resp_valid <= 1'b0;
         resp_datrd <= '0;
         wb.cyc     <= 1'b0;
         wb.stb     <= 1'b0;
         wb.we      <= 1'b0;
         wb.adr     <= '0;
         wb.datwr   <= '0;
         wb.sel     <= '0;
`ifdef WB_MASTER_BRIDGE_TIMEOUT_EN
         resp_err   <= 1'b0;
         tmo_cnt    <= '0;
`endif
      end else begin
         case (state)
            WB_IDLE: begin
               if (req_valid && req_ready) begin
                  state     <= WB_BUS;
                  req_ready <= 1'b0;
                  wb.cyc    <= 1'b1;
                  wb.stb    <= 1'b1;
                  wb.we     <= req_we;
                  wb.adr    <= req_adr;
                  wb.datwr  <= req_we ? req_datwr : '0;
                  wb.sel    <= req_we ? req_sel : '1;
`ifdef WB_MASTER_BRIDGE_TIMEOUT_EN
                  tmo_cnt   <= cnt_load;
`endif
               end else begin
                  req_ready <= 1'b1;
               end
            end
            WB_BUS: begin
               if (wb.ack) begin
                  state      <= WB_RESP;
                  resp_valid <= 1'b1;
                  resp_datrd <= wb.we ? '0 : wb.datrd;
                  wb.cyc     <= 1'b0;
                  wb.stb     <= 1'b0;
                  wb.we      <= 1'b0;
                  wb.adr     <= '0;
                  wb.datwr   <= '0;
                  wb.sel     <= '0;
               end
`ifdef WB_MASTER_BRIDGE_TIMEOUT_EN
               else if (tmo_cnt == '0) begin
                  state      <= WB_RESP;
                  resp_valid <= 1'b1;
                  resp_err   <= 1'b1;
                  resp_datrd <= '0;
                  wb.cyc     <= 1'b0;
                  wb.stb     <= 1'b0;
                  wb.we      <= 1'b0;
                  wb.adr     <= '0;
                  wb.datwr   <= '0;
                  wb.sel     <= '0;
               end else begin
                  tmo_cnt <= tmo_cnt - 1'b1;
               end
`endif
            end
            WB_RESP: begin
               if (resp_ready) begin
                  state      <= WB_IDLE;
                  resp_valid <= 1'b0;
                  resp_datrd <= '0;
                  req_ready  <= 1'b1;
`ifdef WB_MASTER_BRIDGE_TIMEOUT_EN
                  resp_err   <= 1'b0;
`endif
               end
            end
            default: begin
               state     <= WB_IDLE;
               req_ready <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_wb_master_bridge.sv
// Directed bench for wb_master_bridge: reset, read/write transfers, backpressure,
// reset mid-transfer, spurious ack and (with WB_MASTER_BRIDGE_TIMEOUT_EN) ack timeout.
module tb_wb_master_bridge;
   import wb_pkg::*;

   logic        clock = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_adr;
   logic        req_we;
   logic [31:0] req_datwr;
   logic [3:0]  req_sel;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_datrd;
`ifdef WB_MASTER_BRIDGE_TIMEOUT_EN
   logic        resp_err;
`endif

   int tests  = 0;
   int failed = 0;

   wishbone_bus_if #(.adr_width(32), .dat_width(32), .sel_width(4)) wb_bus ();

`ifdef WB_MASTER_BRIDGE_TIMEOUT_EN
   wb_master_bridge #(.adr_width(32), .dat_width(32), .sel_width(4), .timeout_cycles(4)) dut (
`else
   wb_master_bridge #(.adr_width(32), .dat_width(32), .sel_width(4)) dut (
`endif
      .clock      (clock),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_adr    (req_adr),
      .req_we     (req_we),
      .req_datwr  (req_datwr),
      .req_sel    (req_sel),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_datrd (resp_datrd),
`ifdef WB_MASTER_BRIDGE_TIMEOUT_EN
      .resp_err   (resp_err),
`endif
      .wb         (wb_bus.m_modport)
   );

   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive_req(input wb_req_t r);
      req_valid = 1'b1;
      req_adr   = r.adr;
      req_we    = r.we;
      req_datwr = r.datwr;
      req_sel   = r.sel;
   endtask

   task automatic scramble_req();
      req_valid = 1'b0;
      req_adr   = 32'hFFFF_0000;
      req_we    = 1'b1;
      req_datwr = 32'h0BAD_0BAD;
      req_sel   = 4'b1010;
   endtask

   task automatic check_bus_idle(input string tag);
      check({tag, ".cyc"},   64'(wb_bus.cyc),   64'h0);
      check({tag, ".stb"},   64'(wb_bus.stb),   64'h0);
      check({tag, ".we"},    64'(wb_bus.we),    64'h0);
      check({tag, ".adr"},   64'(wb_bus.adr),   64'h0);
      check({tag, ".datwr"}, 64'(wb_bus.datwr), 64'h0);
      check({tag, ".sel"},   64'(wb_bus.sel),   64'h0);
   endtask

   initial begin
      wb_req_t r;
      reset        = 1'b0;
      resp_ready   = 1'b0;
      wb_bus.ack   = 1'b0;
      wb_bus.datrd = 32'h0;
      scramble_req();

      // reset values
      step(); step(); step();
      check("rst.req_ready", 64'(req_ready), 64'h0);
      check("rst.resp_valid", 64'(resp_valid), 64'h0);
      check("rst.resp_datrd", 64'(resp_datrd), 64'h0);
`ifdef WB_MASTER_BRIDGE_TIMEOUT_EN
      check("rst.resp_err", 64'(resp_err), 64'h0);
`endif
      check_bus_idle("rst");

      reset = 1'b1;
      step();
      check("post_rst.req_ready", 64'(req_ready), 64'h1);

      // spurious ack in IDLE
      wb_bus.ack   = 1'b1;
      wb_bus.datrd = 32'h1111_2222;
      step(); step();
      check("spur.resp_valid", 64'(resp_valid), 64'h0);
      check("spur.req_ready", 64'(req_ready), 64'h1);
      check("spur.cyc", 64'(wb_bus.cyc), 64'h0);
      wb_bus.ack   = 1'b0;
      wb_bus.datrd = 32'h0;

      // read, zero wait states, then 5 cycles of response backpressure
      r = '{adr: 32'h100, we: 1'b0, datwr: 32'hAAAA_AAAA, sel: 4'b0101};
      drive_req(r);
      step();
      scramble_req();
      check("rd.cyc", 64'(wb_bus.cyc), 64'h1);
      check("rd.stb", 64'(wb_bus.stb), 64'h1);
      check("rd.we", 64'(wb_bus.we), 64'h0);
      check("rd.adr", 64'(wb_bus.adr), 64'h100);
      check("rd.datwr", 64'(wb_bus.datwr), 64'h0);
      check("rd.sel", 64'(wb_bus.sel), 64'hF);
      check("rd.req_ready", 64'(req_ready), 64'h0);
      wb_bus.ack   = 1'b1;
      wb_bus.datrd = 32'hDEAD_BEEF;
      step();
      wb_bus.ack   = 1'b0;
      wb_bus.datrd = 32'h0;
      r = '{adr: 32'h300, we: 1'b0, datwr: 32'h0, sel: 4'b0};
      drive_req(r);
      for (int i = 0; i < 5; i++) begin
         check("bp.resp_valid", 64'(resp_valid), 64'h1);
         check("bp.resp_datrd", 64'(resp_datrd), 64'hDEAD_BEEF);
         check("bp.req_ready", 64'(req_ready), 64'h0);
         check("bp.cyc", 64'(wb_bus.cyc), 64'h0);
         step();
      end
      resp_ready = 1'b1;
      req_valid  = 1'b0;
      step();
      resp_ready = 1'b0;
      check("bp_done.resp_valid", 64'(resp_valid), 64'h0);
      check("bp_done.req_ready", 64'(req_ready), 64'h1);
      check("bp_done.cyc", 64'(wb_bus.cyc), 64'h0);

      // write with 3 wait states
      r = '{adr: 32'h200, we: 1'b1, datwr: 32'h1234_5678, sel: 4'b0011};
      drive_req(r);
      step();
      scramble_req();
      for (int i = 0; i < 4; i++) begin
         check("wr.cyc", 64'(wb_bus.cyc), 64'h1);
         check("wr.stb", 64'(wb_bus.stb), 64'h1);
         check("wr.we", 64'(wb_bus.we), 64'h1);
         check("wr.adr", 64'(wb_bus.adr), 64'h200);
         check("wr.datwr", 64'(wb_bus.datwr), 64'h1234_5678);
         check("wr.sel", 64'(wb_bus.sel), 64'h3);
         check("wr.resp_valid", 64'(resp_valid), 64'h0);
         if (i == 3) begin
            wb_bus.ack   = 1'b1;
            wb_bus.datrd = 32'hFFFF_FFFF;
         end
         step();
      end
      wb_bus.ack   = 1'b0;
      wb_bus.datrd = 32'h0;
      check("wr_done.resp_valid", 64'(resp_valid), 64'h1);
      check("wr_done.resp_datrd", 64'(resp_datrd), 64'h0);
      check_bus_idle("wr_done");
      resp_ready = 1'b1;
      step();
      resp_ready = 1'b0;
      check("wr_ret.req_ready", 64'(req_ready), 64'h1);

      // reset during wait states; a late ack must not produce a response
      r = '{adr: 32'h300, we: 1'b0, datwr: 32'h0, sel: 4'b0};
      drive_req(r);
      step();
      scramble_req();
      check("rb.cyc", 64'(wb_bus.cyc), 64'h1);
      step();
      reset = 1'b0;
      step();
      reset = 1'b1;
      check_bus_idle("rb");
      check("rb.req_ready", 64'(req_ready), 64'h0);
      check("rb.resp_valid", 64'(resp_valid), 64'h0);
      wb_bus.ack   = 1'b1;
      wb_bus.datrd = 32'h5555_5555;
      step();
      wb_bus.ack   = 1'b0;
      wb_bus.datrd = 32'h0;
      check("rb_late.resp_valid", 64'(resp_valid), 64'h0);
      check("rb_late.cyc", 64'(wb_bus.cyc), 64'h0);
      check("rb_late.req_ready", 64'(req_ready), 64'h1);
      step();
      check("rb_late2.resp_valid", 64'(resp_valid), 64'h0);

`ifdef WB_MASTER_BRIDGE_TIMEOUT_EN
      // no ack: response with resp_err after 4 BUS cycles
      r = '{adr: 32'h400, we: 1'b0, datwr: 32'h0, sel: 4'b0};
      drive_req(r);
      step();
      scramble_req();
      for (int i = 0; i < 4; i++) begin
         check("tmo.cyc", 64'(wb_bus.cyc), 64'h1);
         check("tmo.resp_valid", 64'(resp_valid), 64'h0);
         step();
      end
      check("tmo.resp_valid_end", 64'(resp_valid), 64'h1);
      check("tmo.resp_err", 64'(resp_err), 64'h1);
      check("tmo.resp_datrd", 64'(resp_datrd), 64'h0);
      check("tmo.cyc_end", 64'(wb_bus.cyc), 64'h0);
      resp_ready = 1'b1;
      step();
      resp_ready = 1'b0;
      check("tmo_ret.resp_err", 64'(resp_err), 64'h0);
      check("tmo_ret.req_ready", 64'(req_ready), 64'h1);

      // ack on the limit cycle wins
      r = '{adr: 32'h500, we: 1'b0, datwr: 32'h0, sel: 4'b0};
      drive_req(r);
      step();
      scramble_req();
      for (int i = 0; i < 4; i++) begin
         check("lim.cyc", 64'(wb_bus.cyc), 64'h1);
         if (i == 3) begin
            wb_bus.ack   = 1'b1;
            wb_bus.datrd = 32'hCAFE_F00D;
         end
         step();
      end
      wb_bus.ack   = 1'b0;
      wb_bus.datrd = 32'h0;
      check("lim.resp_valid", 64'(resp_valid), 64'h1);
      check("lim.resp_err", 64'(resp_err), 64'h0);
      check("lim.resp_datrd", 64'(resp_datrd), 64'hCAFE_F00D);
      resp_ready = 1'b1;
      step();
      resp_ready = 1'b0;
`endif

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
